// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and one-cycle key strobe
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_RATE     = 1000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [3:0] caracter,
  output logic       tecla_valida,
  output logic       ocupado
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  state_t          state, state_n;
  logic [3:0]      s1, fs;
  logic [1:0]      col, col_n;
  logic [1:0]      row, row_n;
  logic [DW-1:0]   dwell, dwell_n;
  logic [BW-1:0]   deb, deb_n;
  logic [3:0]      columnas_n, caracter_n;
  logic            valid_n, ocupado_n;
  logic            single;
  logic [1:0]      hit_row;
  logic [3:0]      row_pat;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);
  logic [RW-1:0] rpt, rpt_n;
  logic          armed, armed_n;
`endif

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd10;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd11;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = 4'd12;
      4'hC: code = 4'd14;
      4'hD: code = 4'd0;
      4'hE: code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  // Only a single low row is a key; multiple low rows may be ghosts and are ignored.
  always_comb begin
    single  = 1'b1;
    hit_row = 2'd0;
    case (fs)
      4'b1110: hit_row = 2'd0;
      4'b1101: hit_row = 2'd1;
      4'b1011: hit_row = 2'd2;
      4'b0111: hit_row = 2'd3;
      default: single = 1'b0;
    endcase
  end

  assign row_pat = ~(4'b0001 << row);

  always_comb begin
    state_n    = state;
    col_n      = col;
    row_n      = row;
    dwell_n    = dwell;
    deb_n      = deb;
    caracter_n = caracter;
    valid_n    = 1'b0;
    ocupado_n  = ocupado;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_n = '0;
          if (single) begin
            row_n     = hit_row;
            ocupado_n = 1'b1;
            deb_n     = '0;
            state_n   = DEBOUNCE;
          end else begin
            col_n = col + 2'd1;
          end
        end else begin
          dwell_n = dwell + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (fs == row_pat) begin
          if (deb == DEB_LAST) begin
            caracter_n = key_code(row, col);
            valid_n    = 1'b1;
            state_n    = HOLD;
          end else begin
            deb_n = deb + 1'b1;
          end
        end else begin
          ocupado_n = 1'b0;
          dwell_n   = '0;
          state_n   = SCAN;
        end
      end
      HOLD: begin
        if (fs == 4'hF) begin
          deb_n   = '0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (fs != 4'hF) begin
          state_n = HOLD;
        end else if (deb == DEB_LAST) begin
          ocupado_n = 1'b0;
          col_n     = 2'd0;
          dwell_n   = '0;
          state_n   = SCAN;
        end else begin
          deb_n = deb + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
`ifdef KEYPAD_AUTOREPEAT_EN
    // Repeat timer runs only while the key stays down in HOLD; any exit re-arms the long delay.
    rpt_n   = '0;
    armed_n = 1'b0;
    if (state == HOLD && fs != 4'hF) begin
      armed_n = armed;
      if ((!armed && rpt == RD_LAST) || (armed && rpt == RR_LAST)) begin
        valid_n = 1'b1;
        armed_n = 1'b1;
      end else begin
        rpt_n = rpt + 1'b1;
      end
    end
`endif
    columnas_n = ~(4'b0001 << col_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SCAN;
      s1           <= 4'hF;
      fs           <= 4'hF;
      col          <= 2'd0;
      row          <= 2'd0;
      dwell        <= '0;
      deb          <= '0;
      columnas     <= 4'b1110;
      caracter     <= 4'd0;
      tecla_valida <= 1'b0;
      ocupado      <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt          <= '0;
      armed        <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      s1           <= filas;
      fs           <= s1;
      col          <= col_n;
      row          <= row_n;
      dwell        <= dwell_n;
      deb          <= deb_n;
      columnas     <= columnas_n;
      caracter     <= caracter_n;
      tecla_valida <= valid_n;
      ocupado      <= ocupado_n;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt          <= rpt_n;
      armed        <= armed_n;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with a strobe scoreboard
// Auto-repeat expectations switch on KEYPAD_AUTOREPEAT_EN.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic [3:0] caracter;
  logic       tecla_valida;
  logic       ocupado;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (40),
    .REPEAT_RATE     (10)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .filas        (filas),
    .columnas     (columnas),
    .caracter     (caracter),
    .tecla_valida (tecla_valida),
    .ocupado      (ocupado)
  );

  // Matrix model: a closed key pulls its row low only while its column is driven.
  logic       key_on  = 1'b0;
  logic [1:0] key_row = 2'd0;
  logic [1:0] key_col = 2'd0;
  logic       raw_en  = 1'b0;
  logic [3:0] raw_val = 4'hF;

  always_comb begin
    filas = 4'hF;
    if (raw_en) begin
      if (!columnas[0]) filas = raw_val;
    end else if (key_on && !columnas[key_col]) begin
      filas = ~(4'b0001 << key_row);
    end
  end

  int         cyc = 0;
  int         double_cnt = 0;
  logic       prev_v = 1'b0;
  logic [3:0] strobe_val[$];
  int         strobe_cyc[$];

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    prev_v <= tecla_valida;
    if (tecla_valida && prev_v) double_cnt <= double_cnt + 1;
    if (tecla_valida) begin
      strobe_val.push_back(caracter);
      strobe_cyc.push_back(cyc);
    end
  end

  int         cmp = 0;
  int         err = 0;
  int         rd  = 0;
  logic [3:0] exp_q[$];

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    while (rd < strobe_val.size()) begin
      if (exp_q.size() == 0) check({tag, " unexpected strobe"}, 32'(strobe_val[rd]), 32'hFFFF_FFFF);
      else check({tag, " code"}, 32'(strobe_val[rd]), 32'(exp_q.pop_front()));
      rd++;
    end
    check({tag, " pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_strobes(input string tag, input int target, input int budget);
    int n = 0;
    while (strobe_val.size() < target && n < budget) begin
      step();
      n++;
    end
    check({tag, " strobe arrived"}, 32'(strobe_val.size() >= target), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (ocupado && n < budget) begin
      step();
      n++;
    end
    check({tag, " idle"}, 32'(ocupado), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_col;
    logic       seen_c3, busy;
    int         n, t0;

    rst = 1'b1;
    step(3);
    check("rst columnas", 32'(columnas), 32'hE);
    check("rst caracter", 32'(caracter), 32'h0);
    check("rst tecla_valida", 32'(tecla_valida), 32'h0);
    check("rst ocupado", 32'(ocupado), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check($sformatf("rotate k%0d", k), 32'(columnas), 32'(exp_col));
      step();
    end

    // '5' held then released
    key_row = 2'd1; key_col = 2'd1;
    exp_q.push_back(4'd5);
    key_on = 1'b1;
    wait_strobes("key5", 1, 100);
    check("key5 caracter", 32'(caracter), 32'd5);
    check("key5 ocupado held", 32'(ocupado), 32'd1);
    step(30);
    check("key5 single strobe", 32'(strobe_val.size()), 32'd1);
    key_on = 1'b0;
    step(10);
    check("key5 busy before release debounced", 32'(ocupado), 32'd1);
    step(1);
    check("key5 released", 32'(ocupado), 32'd0);
    check("key5 column restart", 32'(columnas), 32'hE);
    drain("key5");

    // '#' then '*'
    key_row = 2'd3; key_col = 2'd2;
    exp_q.push_back(4'd15);
    key_on = 1'b1;
    wait_strobes("hash", 2, 100);
    check("hash caracter", 32'(caracter), 32'd15);
    step(20);
    key_on = 1'b0;
    wait_idle("hash", 40);
    key_col = 2'd0;
    exp_q.push_back(4'd14);
    key_on = 1'b1;
    wait_strobes("star", 3, 100);
    check("star caracter", 32'(caracter), 32'd14);
    step(20);
    key_on = 1'b0;
    wait_idle("star", 40);
    drain("hash_star");

    // 'A' bouncing on column 3, then stable
    key_row = 2'd0; key_col = 2'd3;
    n = 0;
    while (columnas != 4'b0111 && n < 40) begin
      step();
      n++;
    end
    check("bounce column3 reached", 32'(columnas), 32'h7);
    for (int i = 0; i < 3; i++) begin
      key_on = 1'b1;
      step(5);
      key_on = 1'b0;
      step(2);
    end
    check("bounce no strobe", 32'(strobe_val.size()), 32'd3);
    exp_q.push_back(4'd10);
    key_on = 1'b1;
    wait_strobes("keyA", 4, 100);
    check("keyA caracter", 32'(caracter), 32'd10);
    step(10);
    key_on = 1'b0;
    wait_idle("keyA", 40);
    drain("keyA");

    // two rows low on column 0
    raw_val = 4'b1100;
    raw_en  = 1'b1;
    seen_c3 = 1'b0;
    busy    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (columnas == 4'b0111) seen_c3 = 1'b1;
      if (ocupado) busy = 1'b1;
    end
    raw_en = 1'b0;
    check("multi scanning continues", 32'(seen_c3), 32'd1);
    check("multi never busy", 32'(busy), 32'd0);
    check("multi no strobe", 32'(strobe_val.size()), 32'd4);

    // reset during debounce of 'D'
    key_row = 2'd3; key_col = 2'd3;
    key_on = 1'b1;
    n = 0;
    while (!ocupado && n < 100) begin
      step();
      n++;
    end
    check("keyD detected", 32'(ocupado), 32'd1);
    step(2);
    check("keyD still debouncing", 32'(strobe_val.size()), 32'd4);
    rst = 1'b1;
    key_on = 1'b0;
    step(1);
    check("abort caracter", 32'(caracter), 32'd0);
    check("abort ocupado", 32'(ocupado), 32'd0);
    check("abort columnas", 32'(columnas), 32'hE);
    check("abort tecla_valida", 32'(tecla_valida), 32'd0);
    rst = 1'b0;
    step(30);
    check("abort no strobe", 32'(strobe_val.size()), 32'd4);
    drain("keyD");

    // '0' held 80+ cycles past acceptance
    key_row = 2'd3; key_col = 2'd1;
    exp_q.push_back(4'd0);
`ifdef KEYPAD_AUTOREPEAT_EN
    for (int i = 0; i < 5; i++) exp_q.push_back(4'd0);
`endif
    key_on = 1'b1;
    wait_strobes("key0", 5, 100);
    check("key0 caracter", 32'(caracter), 32'd0);
    t0 = (strobe_cyc.size() > 4) ? strobe_cyc[4] : cyc;
    n = 0;
    while (cyc < t0 + 82 && n < 200) begin
      step();
      n++;
    end
    key_on = 1'b0;
    wait_idle("key0", 40);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("key0 repeat count", 32'(strobe_val.size()), 32'd10);
    for (int i = 1; i <= 5; i++)
      check($sformatf("key0 repeat %0d offset", i),
            (4 + i < strobe_cyc.size()) ? 32'(strobe_cyc[4 + i] - t0) : 32'hFFFF_FFFF,
            32'(30 + 10 * i));
`else
    check("key0 one strobe only", 32'(strobe_val.size()), 32'd5);
`endif
    drain("key0");

    check("no back-to-back strobes", 32'(double_cnt), 32'd0);
    drain("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the keypad-to-LCD character path: scans a 4x4 matrix keypad, debounces, and emits one 4-bit key code per press.
- The 4-bit code feeds the key-code-to-LCD-character converter directly, so code values follow its encoding: 0-9 = digits, A-D = 10-13, * = 14, # = 15.
- A one-cycle strobe marks each accepted press, so downstream logic writes one character per press.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before its rows are sampled; minimum 4.
- DEBOUNCE_CYCLES, 20000: consecutive stable-sample cycles required to accept a press or a release; minimum 2.
- REPEAT_DELAY, 5000000: hold cycles before the first auto-repeat; used only with KEYPAD_AUTOREPEAT_EN.
- REPEAT_RATE, 1000000: cycles between subsequent auto-repeats; used only with KEYPAD_AUTOREPEAT_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- filas  input  4  keypad rows; active-low with external pull-ups; asynchronous to clk
- columnas  output  4  keypad column drive; one-hot active-low
- caracter  output  4  code of the last accepted key
- tecla_valida  output  1  one-cycle pulse when caracter is updated
- ocupado  output  1  high from candidate detection until release is debounced

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - columnas=4'b1110, caracter=0, tecla_valida=0, ocupado=0.
  - State=SCAN, column index=0, all counters=0.
  - Reset asserted mid-debounce or mid-hold aborts with no strobe.
- Synchronisation:
  - filas passes through a 2-flop synchroniser; only the synchronised value fs is used.
  - Adds 2 cycles of latency to every input change.
- Key map (row r = filas bit, col c = columnas bit):
  - r0: 1,2,3,A -> 1,2,3,10
  - r1: 4,5,6,B -> 4,5,6,11
  - r2: 7,8,9,C -> 7,8,9,12
  - r3: *,0,#,D -> 14,0,15,13
- SCAN:
  - Dwell counter counts 0..SCAN_DIV-1 with the current column driven low.
  - fs is sampled only at count SCAN_DIV-1 (settling margin).
  - fs==4'hF: advance to the next column, wrapping 3->0.
  - Exactly one bit of fs low: latch row/col, freeze the column, set ocupado, clear the debounce counter, go to DEBOUNCE.
  - Two or more bits low (ghosting/multi-key): treated as no key; advance the column.
- DEBOUNCE:
  - Each cycle fs equals the latched pattern: counter increments.
  - Any mismatch: ocupado=0, go to SCAN on the same column with the dwell counter cleared.
  - Counter reaches DEBOUNCE_CYCLES-1 with a match: caracter<=code(row,col) and tecla_valida=1 in the same cycle, then go to HOLD.
- HOLD:
  - Column stays frozen.
  - fs==4'hF: clear the counter, go to RELEASE.
  - Any other value, including a changed key: stay in HOLD. No second strobe without a release.
- RELEASE:
  - Count consecutive fs==4'hF.
  - Any low bit: return to HOLD.
  - Reaching DEBOUNCE_CYCLES-1: ocupado=0, column index=0, columnas=4'b1110, go to SCAN.
- Outputs:
  - tecla_valida is never high on two consecutive cycles.
  - caracter holds its value between strobes.
  - All outputs are registered.
- Latency: from a clean press on the driven column, tecla_valida rises at most SCAN_DIV+DEBOUNCE_CYCLES+2 cycles after filas changes.

Optional Feature:
- KEYPAD_AUTOREPEAT_EN defined:
  - In HOLD, a repeat counter starts at entry.
  - After REPEAT_DELAY cycles, tecla_valida pulses with caracter unchanged; further pulses follow every REPEAT_RATE cycles while held.
  - The counter clears on leaving HOLD, including RELEASE->HOLD bounces.
- Undefined: exactly one strobe per press; REPEAT_* parameters and the repeat counter are absent.

Test Plan:
- rst high 3 cycles, filas=4'hF -> columnas=1110, caracter=0, tecla_valida=0; with SCAN_DIV=4, columnas rotates 1110->1101->1011->0111 every 4 cycles, then wraps.
- SCAN_DIV=4, DEBOUNCE_CYCLES=8: press '5' (filas[1] low whenever columnas[1] low), held -> exactly one tecla_valida pulse, caracter=5, ocupado=1 until 8 cycles after release.
- Press '#' (r3,c2) then '*' (r3,c0), each held then released -> caracter=15 then 14, two pulses total.
- Bounce: filas[0] low for 5 cycles on column 3, high 2 cycles, repeat 3 times, then stable -> no pulse during bounce, one pulse caracter=10 after stable debounce.
- filas=4'b1100 (two rows) on column 0 -> no pulse, scanning continues; rst asserted during DEBOUNCE of 'D' -> no pulse, outputs return to reset values.
- With KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY=40, REPEAT_RATE=10: hold '0' for 80 cycles past acceptance -> pulses at acceptance, +40, +50, +60, +70, +80, all caracter=0; without the macro -> one pulse only.
